// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt sequencer for the 5-stage pipeline, with saturating perf counters.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_id_ex,
  input  logic [4:0]       rt_id_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             pc_bj_ex,
  input  logic             halt_ex,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
  logic             run, lu, do_halt, do_bj, do_lu;
  assign run = state_q == RUN;
  assign lu = MemRead_id_ex & (rt_id_ex != 5'd0) &
              ((uses_rs_id & (rs_id == rt_id_ex)) | (uses_rt_id & (rt_id == rt_id_ex)));
  // Priority: halt beats branch/jump, which beats load-use (a stall on the wrong path is moot).
  assign do_halt = run & halt_ex;
  assign do_bj   = run & ~halt_ex & pc_bj_ex;
  assign do_lu   = run & ~halt_ex & ~pc_bj_ex & lu;
  always_comb begin
    pc_en       = run & ~do_halt & ~do_lu;
    if_id_en    = run & ~do_halt & ~do_lu;
    if_id_flush = ~run | do_halt | do_bj;
    id_ex_flush = ~run | do_halt | do_bj | do_lu;
    halted      = state_q == HALTED;
    state_d     = do_halt ? DRAIN :
                  (state_q == DRAIN && drain_q == '0) ? HALTED :
                  (state_q == HALTED && resume) ? RUN : state_q;
    drain_d     = do_halt ? DW'(DRAIN_CYCLES - 1) :
                  (state_q == DRAIN && drain_q != '0) ? drain_q - DW'(1) : drain_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (state_q != HALTED && cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      if (do_lu && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (do_bj && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule
